mc_cu: RTL

Multi-cycle control unit for the MIPS-subset CPU: next generation of the single-cycle controller. It decodes the same instruction set (add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lw, sw, beq, bne, lui, j, jal). It sequences each instruction through IF/ID/EXE/MEM/WB states that share one ALU and one memory port. It adds a memory-ready handshake with optional wait-state timeout, and a sticky error state for illegal opcodes.

---
 rtl/mc_cu_pkg.sv | 95 +++++++++
 rtl/mc_cu_if.sv | 36 +++
 rtl/mc_cu_decode.sv | 70 +++++++
 rtl/mc_cu.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mc_cu_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control unit.
package mc_cu_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd5
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_REG    = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;
  localparam logic [5:0] F_JR  = 6'b001000;

  // Bit positions in the one-hot instruction vector.
  localparam int I_ADD  = 0;
  localparam int I_SUB  = 1;
  localparam int I_AND  = 2;
  localparam int I_OR   = 3;
  localparam int I_XOR  = 4;
  localparam int I_SLL  = 5;
  localparam int I_SRL  = 6;
  localparam int I_SRA  = 7;
  localparam int I_JR   = 8;
  localparam int I_ADDI = 9;
  localparam int I_ANDI = 10;
  localparam int I_ORI  = 11;
  localparam int I_XORI = 12;
  localparam int I_LW   = 13;
  localparam int I_SW   = 14;
  localparam int I_BEQ  = 15;
  localparam int I_BNE  = 16;
  localparam int I_LUI  = 17;
  localparam int I_J    = 18;
  localparam int I_JAL  = 19;
  localparam int NUM_INST = 20;

  typedef struct packed {
    logic       j;
    logic       jal;
    logic       jr;
    logic       beq;
    logic       bne;
    logic       lw;
    logic       sw;
    logic       imm;
    logic [3:0] aluc;
    logic       shift;
    logic       sext;
    logic       regrt;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/mc_cu_if.sv
// Control-unit <-> datapath bundle: instruction fields and flags in, control strobes out.
interface mc_cu_if;
  logic [5:0] op;
  logic [5:0] func;
  logic       z;
  logic       mem_ready;

  logic       wpc;
  logic       wir;
  logic       wmem;
  logic       wreg;
  logic       iord;
  logic       regrt;
  logic       m2reg;
  logic       jal;
  logic       sext;
  logic       shift;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [3:0] aluc;
  logic [1:0] pcsource;
  logic [2:0] state;
  logic       err;

  modport master (
    input  op, func, z, mem_ready,
    output wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift,
           alusrca, alusrcb, aluc, pcsource, state, err
  );

  modport slave (
    output op, func, z, mem_ready,
    input  wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift,
           alusrca, alusrcb, aluc, pcsource, state, err
  );
endinterface

// File: rtl/mc_cu_decode.sv
// Combinational instruction decode: op/func to one-hot instruction, then per-class
// flags and the EXE-phase ALU controls.
module mc_cu_decode import mc_cu_pkg::*; (
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output dec_t       dec_o
);

  logic [NUM_INST-1:0] oh;

  always_comb begin
    oh = '0;
    case (op_i)
      OP_RTYPE: begin
        case (func_i)
          F_ADD:   oh[I_ADD] = 1'b1;
          F_SUB:   oh[I_SUB] = 1'b1;
          F_AND:   oh[I_AND] = 1'b1;
          F_OR:    oh[I_OR]  = 1'b1;
          F_XOR:   oh[I_XOR] = 1'b1;
          F_SLL:   oh[I_SLL] = 1'b1;
          F_SRL:   oh[I_SRL] = 1'b1;
          F_SRA:   oh[I_SRA] = 1'b1;
          F_JR:    oh[I_JR]  = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: oh[I_ADDI] = 1'b1;
      OP_ANDI: oh[I_ANDI] = 1'b1;
      OP_ORI:  oh[I_ORI]  = 1'b1;
      OP_XORI: oh[I_XORI] = 1'b1;
      OP_LW:   oh[I_LW]   = 1'b1;
      OP_SW:   oh[I_SW]   = 1'b1;
      OP_BEQ:  oh[I_BEQ]  = 1'b1;
      OP_BNE:  oh[I_BNE]  = 1'b1;
      OP_LUI:  oh[I_LUI]  = 1'b1;
      OP_J:    oh[I_J]    = 1'b1;
      OP_JAL:  oh[I_JAL]  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    dec_o         = '0;
    dec_o.j       = oh[I_J];
    dec_o.jal     = oh[I_JAL];
    dec_o.jr      = oh[I_JR];
    dec_o.beq     = oh[I_BEQ];
    dec_o.bne     = oh[I_BNE];
    dec_o.lw      = oh[I_LW];
    dec_o.sw      = oh[I_SW];
    dec_o.imm     = oh[I_ADDI] | oh[I_ANDI] | oh[I_ORI] | oh[I_XORI] | oh[I_LUI];
    dec_o.shift   = oh[I_SLL] | oh[I_SRL] | oh[I_SRA];
    dec_o.sext    = oh[I_ADDI] | oh[I_LW] | oh[I_SW] | oh[I_BEQ] | oh[I_BNE];
    dec_o.regrt   = dec_o.imm | oh[I_LW];
    dec_o.illegal = ~|oh;

    // add covers add/addi/lw/sw and anything that never reaches EXE
    if (oh[I_SUB] | oh[I_BEQ] | oh[I_BNE])  dec_o.aluc = ALU_SUB;
    else if (oh[I_AND] | oh[I_ANDI])        dec_o.aluc = ALU_AND;
    else if (oh[I_OR] | oh[I_ORI])          dec_o.aluc = ALU_OR;
    else if (oh[I_XOR] | oh[I_XORI])        dec_o.aluc = ALU_XOR;
    else if (oh[I_LUI])                     dec_o.aluc = ALU_LUI;
    else if (oh[I_SLL])                     dec_o.aluc = ALU_SLL;
    else if (oh[I_SRL])                     dec_o.aluc = ALU_SRL;
    else if (oh[I_SRA])                     dec_o.aluc = ALU_SRA;
    else                                    dec_o.aluc = ALU_ADD;
  end

endmodule

// File: rtl/mc_cu.sv
// Multi-cycle control unit: IF/ID/EXE/MEM/WB sequencer with memory wait-state
// timeout and a sticky error state.
//   state | meaning
//   S_IF  | fetch, PC+4 into PC when memory completes
//   S_ID  | decode, branch target into ALU-out; jumps complete here
//   S_EXE | ALU operation; branches complete here
//   S_MEM | data memory access (lw/sw)
//   S_WB  | register-file write-back
//   S_ERR | illegal instruction or memory timeout, left only by reset
module mc_cu import mc_cu_pkg::*; #(
  parameter bit WAIT_EN = 1'b1,
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 8
) (
  input  logic     clock,
  input  logic     reset,
  mc_cu_if.master  bus
);

  localparam bit               TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  state_e           state_q, state_d, st;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dec_t             dec;
  logic             mem_ok, in_wait, wait_hit;

  logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift, alusrca, err;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] aluc;

  mc_cu_decode u_decode (
    .op_i   (bus.op),
    .func_i (bus.func),
    .dec_o  (dec)
  );

  assign mem_ok   = WAIT_EN ? bus.mem_ready : 1'b1;
  assign in_wait  = (state_q == S_IF) || (state_q == S_MEM);
  assign wait_hit = TO_EN && in_wait && !mem_ok && (cnt_q == TO_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: begin
        if (mem_ok)        state_d = S_ID;
        else if (wait_hit) state_d = S_ERR;
      end
      S_ID: begin
        if (dec.illegal)                   state_d = S_ERR;
        else if (dec.j | dec.jal | dec.jr) state_d = S_IF;
        else                               state_d = S_EXE;
      end
      S_EXE: begin
        if (dec.lw | dec.sw)         state_d = S_MEM;
        else if (dec.beq | dec.bne)  state_d = S_IF;
        else                         state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ok)        state_d = dec.sw ? S_IF : S_WB;
        else if (wait_hit) state_d = S_ERR;
      end
      S_WB:    state_d = S_IF;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase

    // Any state change counts as an entry and restarts the wait count.
    cnt_d = cnt_q;
    if (state_d != state_q)                    cnt_d = '0;
    else if (in_wait && !mem_ok && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    st       = reset ? S_IF : state_q;
    wpc      = 1'b0;
    wir      = 1'b0;
    wmem     = 1'b0;
    wreg     = 1'b0;
    iord     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    sext     = 1'b0;
    shift    = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_REG;
    aluc     = ALU_ADD;
    pcsource = PC_ALU;
    err      = 1'b0;
    case (st)
      S_IF: begin
        alusrcb = SRCB_FOUR;
        wpc     = mem_ok;
        wir     = mem_ok;
      end
      S_ID: begin
        alusrcb = SRCB_BR;
        sext    = 1'b1;
        if (dec.j | dec.jal) begin
          wpc      = 1'b1;
          pcsource = PC_JUMP;
          wreg     = dec.jal;
          jal      = dec.jal;
        end else if (dec.jr) begin
          wpc      = 1'b1;
          pcsource = PC_REG;
        end
      end
      S_EXE: begin
        alusrca = 1'b1;
        shift   = dec.shift;
        sext    = dec.sext;
        aluc    = dec.aluc;
        alusrcb = (dec.imm | dec.lw | dec.sw) ? SRCB_IMM : SRCB_REG;
        if (dec.beq | dec.bne) begin
          pcsource = PC_ALUOUT;
          wpc      = (dec.beq & bus.z) | (dec.bne & ~bus.z);
        end
      end
      S_MEM: begin
        iord = 1'b1;
        wmem = dec.sw & mem_ok;
      end
      S_WB: begin
        wreg  = 1'b1;
        regrt = dec.regrt;
        m2reg = dec.lw;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
    if (reset) begin
      wpc  = 1'b0;
      wir  = 1'b0;
      wmem = 1'b0;
      wreg = 1'b0;
      err  = 1'b0;
    end
  end

  assign bus.wpc      = wpc;
  assign bus.wir      = wir;
  assign bus.wmem     = wmem;
  assign bus.wreg     = wreg;
  assign bus.iord     = iord;
  assign bus.regrt    = regrt;
  assign bus.m2reg    = m2reg;
  assign bus.jal      = jal;
  assign bus.sext     = sext;
  assign bus.shift    = shift;
  assign bus.alusrca  = alusrca;
  assign bus.alusrcb  = alusrcb;
  assign bus.aluc     = aluc;
  assign bus.pcsource = pcsource;
  assign bus.state    = st;
  assign bus.err      = err;

endmodule
